// File: rtl/mem_access_unit_pkg.sv
// Shared types, constants and lane helpers for the MEM-stage access unit.
package mem_access_unit_pkg;

  localparam int          LENGTH         = 32;
  localparam logic [31:0] INITIAL_VAL_32 = 32'h0000_0000;

  // Access size codes as carried on mem_size; 11 is treated as a word.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_BUSY = 2'b01,
    MEM_DONE = 2'b10
  } mem_state_e;

  // Half needs an even address, word (and the illegal code) needs 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

  // Little-endian byte enables for the addressed lane(s).
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  // Replicate the store datum across every lane so the slave can pick by byte enable.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SIZE_BYTE: return {4{wd[7:0]}};
      SIZE_HALF: return {2{wd[15:0]}};
      default:   return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [LENGTH-1:0] rdata_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  output logic [LENGTH-1:0] data_o
);

  logic [LENGTH-1:0] shifted;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // Lane select then extension; the illegal size code behaves as a word.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SIZE_BYTE: data_o = {{24{~uns_i & byte_v[7]}}, byte_v};
      SIZE_HALF: data_o = {{16{~uns_i & half_v[15]}}, half_v};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: issues req/ack bus transactions,
// stalls the pipeline while one is outstanding, flags misaligned accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  mem_state_e        state_q, state_d;
  logic              issue, mis_det, acc;
  logic              bus_req_q, bus_we_q, misalign_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [DATA_W-1:0] bus_wdata_q, read_data_q, aligned;
  logic [1:0]        off_q, size_q;
  logic              uns_q;

  assign acc = mem_read | mem_write;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= MEM_IDLE;
    else     state_q <= state_d;
  end

  // Next state, stall and issue/misalign decode; DONE always falls back to IDLE
  // so the held EX/MEM instruction is never issued twice.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    issue   = 1'b0;
    mis_det = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (acc) begin
          if (is_misaligned(mem_size, addr[1:0])) begin
            mis_det = 1'b1;
          end else begin
            issue   = 1'b1;
            stall   = 1'b1;
            state_d = MEM_BUSY;
          end
        end
      end
      MEM_BUSY: begin
        stall = 1'b1;
        if (bus_ack) state_d = MEM_DONE;
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  mem_access_unit_load_align u_align (
    .rdata_i (bus_rdata),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .data_o  (aligned)
  );

  // Bus request registers, captured load attributes and the load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= INITIAL_VAL_32;
      read_data_q <= INITIAL_VAL_32;
      misalign_q  <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      misalign_q <= mis_det;
      if (issue) begin
        bus_req_q   <= 1'b1;
        bus_we_q    <= mem_write;
        bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        bus_be_q    <= lane_be(mem_size, addr[1:0]);
        bus_wdata_q <= lane_wdata(mem_size, wdata);
        off_q       <= addr[1:0];
        size_q      <= mem_size;
        uns_q       <= mem_unsigned;
      end
      if (state_q == MEM_BUSY && bus_ack) begin
        bus_req_q <= 1'b0;
        if (!bus_we_q) read_data_q <= aligned;
      end
      if (mis_det) read_data_q <= INITIAL_VAL_32;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign read_data = read_data_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected bus transactions are queued
// when an access is driven and compared when bus_req is observed.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic [31:0] read_data;
  logic        stall, misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int checks = 0;
  int failures = 0;
  int exp_issues = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;
  txn_t exp_q[$];

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
    .read_data(read_data), .stall(stall), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  // Count every fresh rise of bus_req to catch duplicate issues.
  always @(posedge clk) begin
    if (bus_req === 1'b1 && req_prev !== 1'b1) req_rises++;
    req_prev = bus_req;
  end

  // Reference lane model.
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) begin
      case (off)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (sz == 2'b01) return (off >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (sz == 2'b01) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] off,
                                         input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = (off >= 2'd2) ? rd[31:16] : rd[15:0];
    if (sz == 2'b00) return (!uns && b[7]) ? {24'hFFFFFF, b} : {24'h000000, b};
    if (sz == 2'b01) return (!uns && h[15]) ? {16'hFFFF, h} : {16'h0000, h};
    return rd;
  endfunction

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0;
  endtask

  // Drives one aligned access, acks it in BUSY cycle ack_cyc (1 = zero wait)
  // and returns in the DONE cycle with the inputs still held.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int ack_cyc, input string nm);
    txn_t t;
    int   w;
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
    t.we = wr; t.addr = {a[31:2], 2'b00}; t.be = m_be(sz, a[1:0]); t.wdata = m_wdata(sz, wd);
    exp_q.push_back(t);
    exp_issues++;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL %s_issue_stall: got %b want 1", nm, stall);
    end
    @(posedge clk); #1;
    w = 0;
    while (bus_req !== 1'b1 && w < 8) begin @(posedge clk); #1; w++; end
    checks++;
    t = exp_q.pop_front();
    if (bus_req !== 1'b1) begin
      failures++; $display("FAIL %s_req_timeout: bus_req=%b want 1", nm, bus_req);
      return;
    end
    checks++;
    if (bus_we !== t.we || bus_addr !== t.addr || bus_be !== t.be ||
        (t.we && bus_wdata !== t.wdata)) begin
      failures++;
      $display("FAIL %s_bus: got we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
               nm, bus_we, bus_addr, bus_be, bus_wdata, t.we, t.addr, t.be, t.wdata);
    end
    for (int k = 1; k <= ack_cyc; k++) begin
      checks++;
      if (stall !== 1'b1 || bus_req !== 1'b1 || bus_addr !== t.addr || bus_be !== t.be) begin
        failures++;
        $display("FAIL %s_busy_c%0d: stall=%b req=%b addr=%h be=%b want 1 1 %h %b",
                 nm, k, stall, bus_req, bus_addr, bus_be, t.addr, t.be);
      end
      if (k == ack_cyc) begin bus_ack = 1'b1; bus_rdata = rdat; end
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
    end
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0) begin
      failures++; $display("FAIL %s_done: stall=%b req=%b want 0 0", nm, stall, bus_req);
    end
    if (!wr) begin
      checks++;
      if (read_data !== m_load(sz, a[1:0], uns, rdat)) begin
        failures++;
        $display("FAIL %s_rdata: got %h want %h", nm, read_data, m_load(sz, a[1:0], uns, rdat));
      end
    end
  endtask

  task automatic finish_access();
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'b0 || bus_addr !== 32'h0 ||
        bus_wdata !== 32'h0 || read_data !== 32'h0 || misalign !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset: req=%b we=%b be=%b addr=%h wd=%h rd=%h mis=%b stall=%b want all 0",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, read_data, misalign, stall);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, "word_load");
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL word_load_const: got %h want deadbeef", read_data);
    end
    finish_access();
  endtask

  task automatic test_byte_loads();
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h80112233, 2, "byte_signed");
    checks++;
    if (read_data !== 32'hFFFFFF80) begin
      failures++; $display("FAIL byte_signed_const: got %h want ffffff80", read_data);
    end
    finish_access();
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h80112233, 1, "byte_unsigned");
    finish_access();
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'h9ABC1234, 2, "half_signed");
    finish_access();
  endtask

  task automatic test_half_store();
    logic [31:0] prev;
    prev = read_data;
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'hFFFF_FFFF, 2, "half_store");
    checks++;
    if (bus_we !== 1'b1 || bus_be !== 4'b1100 || bus_wdata !== 32'hABCDABCD || bus_addr !== 32'h20) begin
      failures++;
      $display("FAIL half_store_const: we=%b be=%b wd=%h addr=%h want 1 1100 abcdabcd 20",
               bus_we, bus_be, bus_wdata, bus_addr);
    end
    checks++;
    if (read_data !== prev) begin
      failures++; $display("FAIL store_keeps_rdata: got %h want %h", read_data, prev);
    end
    finish_access();
    // Read and write together must be treated as a write.
    run_access(1'b1, 1'b1, 2'b00, 1'b0, 32'h29, 32'h000000C3, 32'h0, 1, "rd_wr_both");
    finish_access();
  endtask

  task automatic test_misalign();
    mem_read = 1'b1; mem_size = 2'b10; addr = 32'h06;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL misalign_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (misalign !== 1'b1 || read_data !== 32'h0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse: mis=%b rd=%h req=%b want 1 0 0", misalign, read_data, bus_req);
    end
    @(posedge clk); #1;
    checks++;
    if (misalign !== 1'b0 || bus_req !== 1'b0) begin
      failures++; $display("FAIL misalign_end: mis=%b req=%b want 0 0", misalign, bus_req);
    end
    mem_write = 1'b1; mem_size = 2'b01; addr = 32'h23;
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (misalign !== 1'b1 || bus_req !== 1'b0) begin
      failures++; $display("FAIL misalign_half: mis=%b req=%b want 1 0", misalign, bus_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h01234567, 1, "b2b_load");
    @(posedge clk); #1;
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h45, 32'h00000077, 32'h0, 1, "b2b_store");
    checks++;
    if (read_data !== 32'h01234567) begin
      failures++; $display("FAIL b2b_rdata_hold: got %h want 01234567", read_data);
    end
    finish_access();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL b2b_no_reissue: req=%b stall=%b want 0 0", bus_req, stall);
    end
  endtask

  task automatic test_reset_busy();
    txn_t t;
    mem_write = 1'b1; mem_size = 2'b11; addr = 32'h50; wdata = 32'h12345678;
    t.we = 1'b1; t.addr = 32'h50; t.be = m_be(2'b11, 2'b00); t.wdata = 32'h12345678;
    exp_q.push_back(t);
    exp_issues++;
    @(posedge clk); #1;
    t = exp_q.pop_front();
    checks++;
    if (bus_req !== 1'b1 || bus_be !== t.be || bus_wdata !== t.wdata || bus_addr !== t.addr) begin
      failures++;
      $display("FAIL ill_size_store: req=%b be=%b wd=%h addr=%h want 1 %b %h %h",
               bus_req, bus_be, bus_wdata, bus_addr, t.be, t.wdata, t.addr);
    end
    rst = 1'b1; idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL rst_busy: req=%b stall=%b want 0 0", bus_req, stall);
    end
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL stray_ack: req=%b stall=%b rd=%h want 0 0 0", bus_req, stall, read_data);
    end
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'hCAFEF00D, 2, "post_reset");
    finish_access();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_word_load();
    test_byte_loads();
    test_half_store();
    test_misalign();
    test_back_to_back();
    test_reset_busy();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_rises !== exp_issues) begin
      failures++; $display("FAIL issue_count: got %0d want %0d", req_rises, exp_issues);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit of the MIPS-lite pipeline. It sits between EX/MEM and the MEM/WB pipeline register, and feeds that register's read-memory-data input.
- Issues load/store transactions to a variable-latency data bus using a req/ack handshake.
- Handles byte, halfword and word lanes, plus sign or zero extension on loads.
- Raises stall while a transaction is outstanding and flags misaligned accesses.

Parameters:
- DATA_W, 32, data word width. Only 32 is supported.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_read  in  1  load request from EX/MEM
- mem_write  in  1  store request from EX/MEM
- mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as word)
- mem_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  DATA_W  store data (rt value)
- read_data  out  DATA_W  extended load data, to MEM/WB
- stall  out  1  freeze PC/IF/ID/EX and EX/MEM; hold MEM/WB
- misalign  out  1  one-cycle pulse; access not performed
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- bus_be  out  4  byte enables, little-endian
- bus_wdata  out  DATA_W  lane-replicated store data
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset values:
  - state = IDLE.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata, read_data, misalign = 0.
  - stall = 0.
- Access valid: acc = mem_read | mem_write. If both are set, the access is a write.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- FSM states: IDLE, BUSY, DONE.
- IDLE, aligned acc:
  - stall = 1 combinationally in the same cycle.
  - Next edge: register bus_addr/bus_we/bus_be/bus_wdata, set bus_req = 1, go BUSY.
- IDLE, misaligned acc:
  - No bus activity; stall = 0.
  - misalign = 1 registered, i.e. one cycle after detection, for one cycle.
  - read_data = 0.
  - Stay IDLE.
- BUSY:
  - stall = 1.
  - bus_req and all bus_* outputs are held stable until bus_ack.
  - On bus_ack: clear bus_req; for a load, register the extended bus_rdata into read_data; go DONE.
  - bus_ack in the same cycle bus_req first rises is legal, giving a minimum latency of 2 cycles IDLE→DONE.
- DONE:
  - stall = 0 for exactly one cycle; the pipeline advances and MEM/WB captures read_data.
  - Next state is IDLE unconditionally. This prevents re-issue of the same instruction's access.
- Stall sequencing: a back-to-back access arriving in the cycle after DONE starts a new IDLE→BUSY sequence.
- read_data: holds its value except on a load ack or a misalign.
- bus_ack outside BUSY: ignored.
- Store lanes:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - word: be = 1111.
- Load extraction:
  - Byte selected by addr[1:0], half by addr[1].
  - Sign-extend from bit 7 or bit 15 unless mem_unsigned.
  - Load addr[1:0]/size/unsigned are captured at issue; extraction uses the captured copies.
- Reset mid-transaction: return to IDLE, drop bus_req the next cycle. The bus slave must tolerate an abandoned request.

Decomposition:
- head.v:
  - Add `SIZE_BYTE/`SIZE_HALF/`SIZE_WORD codes and `MEM_IDLE/`MEM_BUSY/`MEM_DONE state encodings.
  - Reuse `LENGTH and `INITIAL_VAL_32.
- One sub-module, load_align: combinational extraction and sign/zero extension from (rdata, addr[1:0], size, unsigned).

Test Plan:
- Word load: addr=0x10, bus_rdata=0xDEADBEEF, ack after 3 cycles → stall high 4 cycles, DONE with read_data=0xDEADBEEF, bus_be=1111.
- Signed byte load: addr=0x13, rdata=0x80112233 → read_data=0xFFFFFF80. Same access unsigned → 0x00000080.
- Half store: addr=0x22, wdata=0x0000ABCD → bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x20.
- Misaligned word load at addr=0x06 → bus_req never rises, stall=0, misalign pulses 1 cycle, read_data=0.
- Zero-wait ack (ack in first BUSY cycle) followed by a back-to-back store → two distinct transactions, no re-issue, stall drops exactly 1 cycle between them.
- rst asserted while BUSY → next cycle bus_req=0, stall=0, state IDLE; a later ack is ignored.
